draw_board_squares: RTL and testbench

- Parametrised successor to the single-square overlay stages: one block draws every filled cell of a GRID_N x GRID_N board plus a blinking cursor cell.
- Sits in the VGA pixel pipeline between the background/grid drawer and the mouse/text overlays.
- Passes timing signals through with a fixed 2-cycle latency.
- Replaces the chain of per-square draw stages.

---
 rtl/draw_board_squares.sv | 242 ++++++++++++++++++++++++
 tb/tb_draw_board_squares.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_board_squares.sv
// draw_board_squares
// ------------------
// Draws every filled cell of a GRID_N x GRID_N board, plus a blinking cursor
// cell, on top of the incoming VGA pixel stream. It sits after the
// background/grid drawer and before the mouse/text overlays. Every output,
// including the timing outputs, lags its input by exactly 2 pclk cycles.
//
// Optional feature (macro DRAW_BOARD_SQUARES_BORDER_EN):
//   When defined, pixels within BORDER_W of any edge of a filled or cursor
//   cell pass rgb_in through, so the grid lines stay visible.
//   When undefined, cells are filled edge to edge and BORDER_W is ignored.
//
// Ports:
//   pclk, rst          pixel clock, asynchronous active-high reset
//   hcount_in/vcount_in, hsync_in/vsync_in, hblnk_in/vblnk_in, rgb_in
//                      upstream pixel stream
//   start_en           game started
//   choice_en          player-choice screen active (suppresses drawing)
//   square_mask        bit k set = cell k filled, k = row*GRID_N + col
//   square_color       fill colour for filled cells
//   cursor_idx         cursor cell; values >= GRID_N*GRID_N mean no cursor
//   cursor_color       cursor highlight colour
//   *_out              2-cycle delayed timing plus composited rgb_out
//
// Handshake: there is none. The block is a free-running pipeline: one pixel
// enters and one pixel leaves on every pclk edge, with no stalls.
//
// Debug: the FSM state is held in the register `state` (IDLE=0, ACTIVE=1);
// the blink state is in `blink_phase` and `frame_cnt`.

module draw_board_squares #(
  parameter int GRID_N       = 3,
  parameter int CELL_W       = 341,
  parameter int CELL_H       = 256,
  parameter int ORIGIN_X     = 0,
  parameter int ORIGIN_Y     = 0,
  parameter int BLINK_FRAMES = 30,
  parameter int BORDER_W     = 2
) (
  input  logic                       pclk,
  input  logic                       rst,
  input  logic [10:0]                hcount_in,
  input  logic [10:0]                vcount_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       hblnk_in,
  input  logic                       vblnk_in,
  input  logic [11:0]                rgb_in,
  input  logic                       start_en,
  input  logic                       choice_en,
  input  logic [GRID_N*GRID_N-1:0]   square_mask,
  input  logic [11:0]                square_color,
  input  logic [3:0]                 cursor_idx,
  input  logic [11:0]                cursor_color,
  output logic [10:0]                hcount_out,
  output logic [10:0]                vcount_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic                       hblnk_out,
  output logic                       vblnk_out,
  output logic [11:0]                rgb_out
);

  localparam int N_CELLS = GRID_N * GRID_N;

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state;
  logic        blink_phase;
  logic [15:0] frame_cnt;

  // ---------------------------------------------------------------- stage 1
  // All bound arithmetic is done at 32 bits so nothing can wrap.
  logic [31:0] h32, v32, col_start, row_start;
  logic [7:0]  col_c, row_c;
  logic        inside_c;

  always_comb begin
    h32       = {21'd0, hcount_in};
    v32       = {21'd0, vcount_in};
    col_c     = '0;
    row_c     = '0;
    col_start = 32'(ORIGIN_X);
    row_start = 32'(ORIGIN_Y);
    // Last matching boundary wins, so the first pixel of a cell belongs to it.
    for (int c = 0; c < GRID_N; c++) begin
      if (h32 >= 32'(ORIGIN_X + c * CELL_W)) begin
        col_c     = 8'(c);
        col_start = 32'(ORIGIN_X + c * CELL_W);
      end
      if (v32 >= 32'(ORIGIN_Y + c * CELL_H)) begin
        row_c     = 8'(c);
        row_start = 32'(ORIGIN_Y + c * CELL_H);
      end
    end
    inside_c = (h32 >= 32'(ORIGIN_X)) &&
               (h32 <= 32'(ORIGIN_X + GRID_N * CELL_W - 1)) &&
               (v32 >= 32'(ORIGIN_Y)) &&
               (v32 <= 32'(ORIGIN_Y + GRID_N * CELL_H - 1));
  end

  logic [10:0] hcount_1, vcount_1;
  logic        hsync_1, vsync_1, hblnk_1, vblnk_1, blank_1, inside_1;
  logic [11:0] rgb_1;
  logic [7:0]  col_1, row_1;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_1 <= '0;
      vcount_1 <= '0;
      hsync_1  <= 1'b0;
      vsync_1  <= 1'b0;
      hblnk_1  <= 1'b0;
      vblnk_1  <= 1'b0;
      blank_1  <= 1'b0;
      inside_1 <= 1'b0;
      rgb_1    <= '0;
      col_1    <= '0;
      row_1    <= '0;
    end else begin
      hcount_1 <= hcount_in;
      vcount_1 <= vcount_in;
      hsync_1  <= hsync_in;
      vsync_1  <= vsync_in;
      hblnk_1  <= hblnk_in;
      vblnk_1  <= vblnk_in;
      blank_1  <= hblnk_in | vblnk_in;
      inside_1 <= inside_c;
      rgb_1    <= rgb_in;
      col_1    <= col_c;
      row_1    <= row_c;
    end
  end

  // Inset border: pixel offsets inside the cell travel with col/row.
  logic border_hit;
`ifdef DRAW_BOARD_SQUARES_BORDER_EN
  logic [15:0] x_off_1, y_off_1;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      x_off_1 <= '0;
      y_off_1 <= '0;
    end else begin
      x_off_1 <= 16'(h32 - col_start);
      y_off_1 <= 16'(v32 - row_start);
    end
  end

  assign border_hit = ({16'd0, x_off_1} < 32'(BORDER_W)) ||
                      ({16'd0, x_off_1} > 32'(CELL_W - 1 - BORDER_W)) ||
                      ({16'd0, y_off_1} < 32'(BORDER_W)) ||
                      ({16'd0, y_off_1} > 32'(CELL_H - 1 - BORDER_W));
`else
  logic [31:0] unused_border;
  assign unused_border = 32'(BORDER_W) ^ col_start ^ row_start;
  assign border_hit    = 1'b0;
`endif

  // ---------------------------------------------------------------- stage 2
  logic [15:0] cell_k;
  logic        mask_hit, cursor_hit;

  always_comb begin
    cell_k   = 16'(row_1) * 16'(GRID_N) + 16'(col_1);
    mask_hit = 1'b0;
    for (int k = 0; k < N_CELLS; k++) begin
      if (cell_k == 16'(k)) mask_hit = square_mask[k];
    end
    cursor_hit = blink_phase &&
                 ({28'd0, cursor_idx} < 32'(N_CELLS)) &&
                 ({12'd0, cursor_idx} == cell_k);
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hsync_out  <= 1'b0;
      vsync_out  <= 1'b0;
      hblnk_out  <= 1'b0;
      vblnk_out  <= 1'b0;
      rgb_out    <= '0;
    end else begin
      hcount_out <= hcount_1;
      vcount_out <= vcount_1;
      hsync_out  <= hsync_1;
      vsync_out  <= vsync_1;
      hblnk_out  <= hblnk_1;
      vblnk_out  <= vblnk_1;
      if (state == IDLE || blank_1 || !inside_1)
        rgb_out <= rgb_1;
      else if (mask_hit && !border_hit)
        rgb_out <= square_color;
      else if (cursor_hit && !border_hit)
        rgb_out <= cursor_color;
      else
        rgb_out <= rgb_1;
    end
  end

  // ------------------------------------------------------------ FSM + blink
  // vsync_1 doubles as the registered vsync for edge detection.
  logic go, vs_rise;
  assign go      = start_en && !choice_en;
  assign vs_rise = vsync_in && !vsync_1;

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      blink_phase <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Entry takes precedence over a coincident vsync edge.
          if (go) begin
            state       <= ACTIVE;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!go) begin
            state       <= IDLE;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
          end else if (vs_rise) begin
            if (frame_cnt >= 16'(BLINK_FRAMES - 1)) begin
              frame_cnt   <= '0;
              blink_phase <= ~blink_phase;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_board_squares.sv
module tb_draw_board_squares;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic        start_en = 1'b0, choice_en = 1'b0;
  logic [8:0]  square_mask = '0;
  logic [11:0] square_color = '0;
  logic [3:0]  cursor_idx = 4'd15;
  logic [11:0] cursor_color = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int checks   = 0;
  int failures = 0;

  localparam logic [11:0] SQ  = 12'hF00;
  localparam logic [11:0] CUR = 12'h0F0;
  localparam logic [11:0] BG  = 12'h123;

  draw_board_squares #(.BLINK_FRAMES(2)) dut (
    .pclk(pclk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start_en(start_en), .choice_en(choice_en),
    .square_mask(square_mask), .square_color(square_color),
    .cursor_idx(cursor_idx), .cursor_color(cursor_color),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  // ------------------------------------------------------ clock and reset
  always #5 pclk = ~pclk;

  // ------------------------------------------------------ driver tasks
  // Hold a pixel for two edges so it reaches rgb_out, then sample #1 later.
  task automatic apply(input int h, input int v);
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    @(posedge pclk);
    @(posedge pclk);
    #1;
  endtask

  task automatic vsync_pulse();
    vsync_in = 1'b1;
    @(posedge pclk); #1;
    vsync_in = 1'b0;
    @(posedge pclk); #1;
  endtask

  // ------------------------------------------------------ tests
  task automatic test_reset();
    #1;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 40'd0) begin
      failures++;
      $display("FAIL reset_initial got rgb=%h h=%0d v=%0d exp all 0", rgb_out, hcount_out, vcount_out);
    end
    #2 rst = 1'b0;
    choice_en = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 12'hABC;
    apply(100, 600);
    checks++;
    if (rgb_out !== 12'hABC || hcount_out !== 11'd100 || hsync_out !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_nonzero got rgb=%h h=%0d hs=%b exp rgb=abc h=100 hs=1", rgb_out, hcount_out, hsync_out);
    end
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== 40'd0) begin
      failures++;
      $display("FAIL async_reset got rgb=%h h=%0d v=%0d hs=%b vs=%b exp all 0",
               rgb_out, hcount_out, vcount_out, hsync_out, vsync_out);
    end
    @(negedge pclk);
    rst = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    start_en = 1'b1; choice_en = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if (dut.state !== 1'b1) begin
      failures++;
      $display("FAIL fsm_active got=%b exp=1", dut.state);
    end
  endtask

  task automatic test_cell_fill();
    int hs[5]           = '{100, 340, 341, 100, 1023};
    int vs[5]           = '{600, 767, 600, 511, 600};
    logic [11:0] ex[5]  = '{SQ, SQ, BG, BG, BG};
    square_mask  = 9'b001_000_000;
    square_color = SQ;
    cursor_color = CUR;
    cursor_idx   = 4'd15;
    rgb_in       = BG;
    for (int i = 0; i < 5; i++) begin
      apply(hs[i], vs[i]);
      checks++;
      if (rgb_out !== ex[i]) begin
        failures++;
        $display("FAIL cell_fill(%0d,%0d) got=%h exp=%h", hs[i], vs[i], rgb_out, ex[i]);
      end
    end
  endtask

  task automatic test_choice_suppress();
    choice_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      hcount_in = 11'(100 + i * 20);
      vcount_in = 11'(600 + i);
      hsync_in  = i[0];
      vsync_in  = i[1];
      hblnk_in  = i[2];
      vblnk_in  = ~i[0];
      rgb_in    = 12'(i * 273 + 5);
      @(posedge pclk); #1;
      if (i >= 1) begin
        checks++;
        if (rgb_out !== 12'((i - 1) * 273 + 5)) begin
          failures++;
          $display("FAIL choice_rgb[%0d] got=%h exp=%h", i, rgb_out, 12'((i - 1) * 273 + 5));
        end
        checks++;
        if (hcount_out !== 11'(100 + (i - 1) * 20) || vcount_out !== 11'(600 + i - 1) ||
            hsync_out !== (i - 1) % 2 == 1 || vsync_out !== ((i - 1) / 2) % 2 == 1 ||
            hblnk_out !== ((i - 1) / 4) % 2 == 1 || vblnk_out !== (i - 1) % 2 == 0) begin
          failures++;
          $display("FAIL timing_delay[%0d] got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b exp h=%0d v=%0d",
                   i, hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out,
                   100 + (i - 1) * 20, 600 + i - 1);
        end
      end
    end
    hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
    rgb_in = BG;
    @(posedge pclk); #1;
  endtask

  task automatic test_blink();
    logic [11:0] e;
    square_mask = '0;
    cursor_idx  = 4'd4;
    choice_en   = 1'b0;
    @(posedge pclk); #1;
    apply(500, 400);
    checks++;
    if (rgb_out !== CUR) begin
      failures++;
      $display("FAIL blink_frame0 got=%h exp=%h", rgb_out, CUR);
    end
    for (int f = 1; f <= 5; f++) begin
      vsync_pulse();
      apply(500, 400);
      e = ((f / 2) % 2 == 0) ? CUR : BG;
      checks++;
      if (rgb_out !== e) begin
        failures++;
        $display("FAIL blink_frame%0d got=%h exp=%h", f, rgb_out, e);
      end
    end
    cursor_idx = 4'd9;
    apply(500, 400);
    checks++;
    if (rgb_out !== BG) begin
      failures++;
      $display("FAIL cursor_idx9 got=%h exp=%h", rgb_out, BG);
    end
    cursor_idx = 4'd15;
    apply(500, 400);
    checks++;
    if (rgb_out !== BG) begin
      failures++;
      $display("FAIL cursor_idx15 got=%h exp=%h", rgb_out, BG);
    end
  endtask

  task automatic test_priority();
    square_mask = 9'b000_010_000;
    cursor_idx  = 4'd4;
    apply(500, 400);
    checks++;
    if (rgb_out !== SQ) begin
      failures++;
      $display("FAIL prio_phase1 got=%h exp=%h", rgb_out, SQ);
    end
    vsync_pulse();
    apply(500, 400);
    checks++;
    if (rgb_out !== SQ) begin
      failures++;
      $display("FAIL prio_phase0 got=%h exp=%h", rgb_out, SQ);
    end
    hblnk_in = 1'b1;
    apply(500, 400);
    checks++;
    if (rgb_out !== BG) begin
      failures++;
      $display("FAIL blank_passthru got=%h exp=%h", rgb_out, BG);
    end
    hblnk_in = 1'b0;
  endtask

  task automatic test_border();
    int hs[4] = '{1, 2, 339, 338};
    int vs[4] = '{1, 2, 100, 100};
    logic [11:0] ex[4];
`ifdef DRAW_BOARD_SQUARES_BORDER_EN
    ex = '{BG, SQ, BG, SQ};
`else
    ex = '{SQ, SQ, SQ, SQ};
`endif
    square_mask = 9'b000_000_001;
    cursor_idx  = 4'd15;
    for (int i = 0; i < 4; i++) begin
      apply(hs[i], vs[i]);
      checks++;
      if (rgb_out !== ex[i]) begin
        failures++;
        $display("FAIL border(%0d,%0d) got=%h exp=%h", hs[i], vs[i], rgb_out, ex[i]);
      end
    end
  endtask

  // ------------------------------------------------------ sequence + report
  initial begin
    test_reset();
    test_cell_fill();
    test_choice_suppress();
    test_blink();
    test_priority();
    test_border();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
